// File: rtl/vga_sprite_engine_if.sv
`default_nettype none
// ============================================================================
// Module   : vga_sprite_engine_if
// Purpose  : Sprite ROM bus between the engine (master) and the bitmap ROM.
// Revision : 1.0
// ============================================================================
interface vga_sprite_engine_if #(
    parameter int NUM_FRAMES = 2,
    parameter int SPRITE_W   = 34,
    parameter int SPRITE_H   = 22
);
    localparam int c_FRAME_W = (NUM_FRAMES > 1) ? $clog2(NUM_FRAMES) : 1;
    localparam int c_ROMX_W  = (SPRITE_W > 1) ? $clog2(SPRITE_W) : 1;
    localparam int c_ROMY_W  = (SPRITE_H > 1) ? $clog2(SPRITE_H) : 1;

    logic [c_FRAME_W-1:0] rom_frame;
    logic [c_ROMX_W-1:0]  rom_x;
    logic [c_ROMY_W-1:0]  rom_y;
    // {opaque, r[1:0], g[1:0], b[1:0]}
    logic [6:0]           rom_pixel;

    modport master (output rom_frame, output rom_x, output rom_y, input rom_pixel);
    modport slave  (input rom_frame, input rom_x, input rom_y, output rom_pixel);
endinterface
`default_nettype wire

// File: rtl/vga_sprite_engine.sv
`default_nettype none
// ============================================================================
// Module   : vga_sprite_engine
// Purpose  : VGA timing plus one scaled, animated, bouncing sprite on a solid
//            background, driving the 8-bit VGA PMOD through a 2-stage pipe.
// Revision : 1.0
// ============================================================================
module vga_sprite_engine #(
    parameter int VGA_WIDTH        = 640,
    parameter int VGA_HEIGHT       = 480,
    parameter int H_FRONT_PORCH    = 16,
    parameter int H_SYNC_PULSE     = 96,
    parameter int H_BACK_PORCH     = 48,
    parameter int V_FRONT_PORCH    = 10,
    parameter int V_SYNC_PULSE     = 2,
    parameter int V_BACK_PORCH     = 33,
    parameter int SYNC_ACTIVE_HIGH = 0,
    parameter int SPRITE_W         = 34,
    parameter int SPRITE_H         = 22,
    parameter int SCALE_BITS       = 3,
    parameter int NUM_FRAMES       = 2,
    parameter int FRAME_PERIOD     = 16,
    parameter int START_X          = 128,
    parameter int START_Y          = 128,
    parameter int SPEED            = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [5:0]                 bg_color,
    vga_sprite_engine_if.master        rom_bus,
    output logic                       frame_start,
    output logic [7:0]                 vga_pmod
);
    localparam int c_H_TOTAL  = VGA_WIDTH + H_FRONT_PORCH + H_SYNC_PULSE + H_BACK_PORCH;
    localparam int c_V_TOTAL  = VGA_HEIGHT + V_FRONT_PORCH + V_SYNC_PULSE + V_BACK_PORCH;
    localparam int c_XC_W     = $clog2(c_H_TOTAL);
    localparam int c_YC_W     = $clog2(c_V_TOTAL);
    localparam int c_CX_W     = c_XC_W + 1;
    localparam int c_CY_W     = c_YC_W + 1;
    localparam int c_PX_W     = $clog2(VGA_WIDTH);
    localparam int c_PY_W     = $clog2(VGA_HEIGHT);
    localparam int c_NX_W     = c_PX_W + 1;
    localparam int c_NY_W     = c_PY_W + 1;
    localparam int c_SPR_PW   = SPRITE_W << SCALE_BITS;
    localparam int c_SPR_PH   = SPRITE_H << SCALE_BITS;
    localparam int c_X_MAX    = VGA_WIDTH - c_SPR_PW;
    localparam int c_Y_MAX    = VGA_HEIGHT - c_SPR_PH;
    localparam int c_HS_START = VGA_WIDTH + H_FRONT_PORCH;
    localparam int c_HS_END   = c_HS_START + H_SYNC_PULSE;
    localparam int c_VS_START = VGA_HEIGHT + V_FRONT_PORCH;
    localparam int c_VS_END   = c_VS_START + V_SYNC_PULSE;
    localparam int c_FRAME_W  = (NUM_FRAMES > 1) ? $clog2(NUM_FRAMES) : 1;
    localparam int c_ANIM_W   = (FRAME_PERIOD > 1) ? $clog2(FRAME_PERIOD) : 1;
    localparam int c_ROMX_W   = (SPRITE_W > 1) ? $clog2(SPRITE_W) : 1;
    localparam int c_ROMY_W   = (SPRITE_H > 1) ? $clog2(SPRITE_H) : 1;
    localparam logic c_SYNC_ON = (SYNC_ACTIVE_HIGH != 0);

    if (c_SPR_PW > VGA_WIDTH || c_SPR_PH > VGA_HEIGHT || NUM_FRAMES < 1 || FRAME_PERIOD < 1)
    begin : g_param_check
        $error("vga_sprite_engine: sprite does not fit the screen or bad animation parameters");
    end

    logic [c_XC_W-1:0]    r_x;
    logic [c_YC_W-1:0]    r_y;
    logic [c_PX_W-1:0]    r_pos_x;
    logic [c_PY_W-1:0]    r_pos_y;
    logic                 r_dir_x_neg;
    logic                 r_dir_y_neg;
    logic [c_ANIM_W-1:0]  r_anim_cnt;
    logic [c_FRAME_W-1:0] r_anim_frame;
    logic                 r_s1_in_sprite;
    logic                 r_s1_active;
    logic                 r_s1_hs;
    logic                 r_s1_vs;

    logic                 w_x_last;
    logic                 w_y_last;
    logic                 w_wrap;
    logic [c_CX_W-1:0]    w_x_ext;
    logic [c_CY_W-1:0]    w_y_ext;
    logic [c_CX_W-1:0]    w_px_ext;
    logic [c_CY_W-1:0]    w_py_ext;
    logic [c_CX_W-1:0]    w_dx;
    logic [c_CY_W-1:0]    w_dy;
    logic                 w_in_sprite;
    logic                 w_active;
    logic                 w_hs;
    logic                 w_vs;
    logic [c_NX_W-1:0]    w_x_up;
    logic [c_NY_W-1:0]    w_y_up;
    logic [c_PX_W-1:0]    w_pos_x_nxt;
    logic [c_PY_W-1:0]    w_pos_y_nxt;
    logic                 w_dir_x_nxt;
    logic                 w_dir_y_nxt;
    logic [5:0]           w_color;
    logic                 w_hs_lvl;
    logic                 w_vs_lvl;

    assign w_x_last = (r_x == c_XC_W'(c_H_TOTAL - 1));
    assign w_y_last = (r_y == c_YC_W'(c_V_TOTAL - 1));
    assign w_wrap   = w_x_last && w_y_last;

    assign w_x_ext  = c_CX_W'(r_x);
    assign w_y_ext  = c_CY_W'(r_y);
    assign w_px_ext = c_CX_W'(r_pos_x);
    assign w_py_ext = c_CY_W'(r_pos_y);
    // Offsets are only latched while inside the sprite, so underflow never escapes.
    assign w_dx     = w_x_ext - w_px_ext;
    assign w_dy     = w_y_ext - w_py_ext;

    assign w_in_sprite = (w_x_ext >= w_px_ext) && (w_x_ext < w_px_ext + c_CX_W'(c_SPR_PW))
                      && (w_y_ext >= w_py_ext) && (w_y_ext < w_py_ext + c_CY_W'(c_SPR_PH));
    assign w_active    = (w_x_ext < c_CX_W'(VGA_WIDTH)) && (w_y_ext < c_CY_W'(VGA_HEIGHT));
    assign w_hs        = (w_x_ext >= c_CX_W'(c_HS_START)) && (w_x_ext < c_CX_W'(c_HS_END));
    assign w_vs        = (w_y_ext >= c_CY_W'(c_VS_START)) && (w_y_ext < c_CY_W'(c_VS_END));

    assign w_x_up = c_NX_W'(r_pos_x) + c_NX_W'(SPEED);
    assign w_y_up = c_NY_W'(r_pos_y) + c_NY_W'(SPEED);

    always_comb begin
        w_pos_x_nxt = r_pos_x;
        w_dir_x_nxt = r_dir_x_neg;
        if (!r_dir_x_neg) begin
            if (w_x_up > c_NX_W'(c_X_MAX)) begin
                w_pos_x_nxt = c_PX_W'(c_X_MAX);
                w_dir_x_nxt = 1'b1;
            end else begin
                w_pos_x_nxt = w_x_up[c_PX_W-1:0];
            end
        end else if (c_NX_W'(r_pos_x) < c_NX_W'(SPEED)) begin
            w_pos_x_nxt = '0;
            w_dir_x_nxt = 1'b0;
        end else begin
            w_pos_x_nxt = r_pos_x - c_PX_W'(SPEED);
        end
    end

    always_comb begin
        w_pos_y_nxt = r_pos_y;
        w_dir_y_nxt = r_dir_y_neg;
        if (!r_dir_y_neg) begin
            if (w_y_up > c_NY_W'(c_Y_MAX)) begin
                w_pos_y_nxt = c_PY_W'(c_Y_MAX);
                w_dir_y_nxt = 1'b1;
            end else begin
                w_pos_y_nxt = w_y_up[c_PY_W-1:0];
            end
        end else if (c_NY_W'(r_pos_y) < c_NY_W'(SPEED)) begin
            w_pos_y_nxt = '0;
            w_dir_y_nxt = 1'b0;
        end else begin
            w_pos_y_nxt = r_pos_y - c_PY_W'(SPEED);
        end
    end

    // Stage 0: raster counters, plus per-frame motion/animation at the wrap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_x          <= '0;
            r_y          <= '0;
            r_pos_x      <= c_PX_W'(START_X);
            r_pos_y      <= c_PY_W'(START_Y);
            r_dir_x_neg  <= 1'b0;
            r_dir_y_neg  <= 1'b0;
            r_anim_cnt   <= '0;
            r_anim_frame <= '0;
            frame_start  <= 1'b0;
        end else begin
            frame_start <= w_wrap;
            if (w_x_last) begin
                r_x <= '0;
                r_y <= w_y_last ? '0 : r_y + c_YC_W'(1);
            end else begin
                r_x <= r_x + c_XC_W'(1);
            end
            if (w_wrap) begin
                r_pos_x     <= w_pos_x_nxt;
                r_pos_y     <= w_pos_y_nxt;
                r_dir_x_neg <= w_dir_x_nxt;
                r_dir_y_neg <= w_dir_y_nxt;
                if (r_anim_cnt == c_ANIM_W'(FRAME_PERIOD - 1)) begin
                    r_anim_cnt   <= '0;
                    r_anim_frame <= (r_anim_frame == c_FRAME_W'(NUM_FRAMES - 1))
                                    ? '0 : r_anim_frame + c_FRAME_W'(1);
                end else begin
                    r_anim_cnt <= r_anim_cnt + c_ANIM_W'(1);
                end
            end
        end
    end

    // Stage 1: ROM address and delayed flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rom_bus.rom_x     <= '0;
            rom_bus.rom_y     <= '0;
            rom_bus.rom_frame <= '0;
            r_s1_in_sprite    <= 1'b0;
            r_s1_active       <= 1'b0;
            r_s1_hs           <= 1'b0;
            r_s1_vs           <= 1'b0;
        end else begin
            r_s1_in_sprite <= w_in_sprite;
            r_s1_active    <= w_active;
            r_s1_hs        <= w_hs;
            r_s1_vs        <= w_vs;
            if (w_in_sprite) begin
                rom_bus.rom_x     <= c_ROMX_W'(w_dx >> SCALE_BITS);
                rom_bus.rom_y     <= c_ROMY_W'(w_dy >> SCALE_BITS);
                rom_bus.rom_frame <= r_anim_frame;
            end
        end
    end

    always_comb begin
        w_color = 6'd0;
        if (r_s1_active && r_s1_in_sprite && rom_bus.rom_pixel[6]) begin
            w_color = rom_bus.rom_pixel[5:0];
        end else if (r_s1_active) begin
            w_color = bg_color;
        end
    end

    assign w_hs_lvl = c_SYNC_ON ? r_s1_hs : ~r_s1_hs;
    assign w_vs_lvl = c_SYNC_ON ? r_s1_vs : ~r_s1_vs;

    // Stage 2: PMOD pin order {hs, b0, g0, r0, vs, b1, g1, r1}.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vga_pmod <= {~c_SYNC_ON, 3'b000, ~c_SYNC_ON, 3'b000};
        end else begin
            vga_pmod <= {w_hs_lvl, w_color[0], w_color[2], w_color[4],
                         w_vs_lvl, w_color[1], w_color[3], w_color[5]};
        end
    end
endmodule
`default_nettype wire
